arith_unit_mc: RTL and testbench

ARITH_UNIT_MC -- requirements
Module: arith_unit_mc

---
 rtl/arith_unit_mc.sv | 166 ++++++++++++++++
 tb/tb_arith_unit_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_mc.sv
// arith_unit_mc -- multi-cycle unsigned arithmetic unit.
//
// Add, subtract and multiply finish in one cycle. A divide by zero also
// finishes in one cycle. A divide by a nonzero B runs a restoring divider
// that produces one quotient bit per cycle, so the result arrives
// DATA_WIDTH cycles after the request is accepted.
//
// Ports:
//   Clk         - clock; all state changes on its rising edge
//   RST         - asynchronous reset, active low
//   A, B        - unsigned operands, DATA_WIDTH bits each
//   ALU_FUN     - operation: 00 add, 01 subtract, 10 multiply, 11 divide
//   In_Valid    - request qualifier
//   In_Ready    - high when a request can be accepted (idle)
//   Arith_out   - sum, difference, low word of the product, or quotient
//   Arith_hi    - high word of the product, or remainder; zero for add/sub
//   Carry_out   - add carry, subtract borrow, or multiply overflow
//   Div_By_Zero - set with the result of a divide whose B was zero
//   Out_Valid   - one-cycle pulse marking a new result
//   Busy        - high while a division is iterating
module arith_unit_mc #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            ALU_FUN,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic [DATA_WIDTH-1:0] Arith_out,
  output logic [DATA_WIDTH-1:0] Arith_hi,
  output logic                  Carry_out,
  output logic                  Div_By_Zero,
  output logic                  Out_Valid,
  output logic                  Busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    quo, rem, dvsr;

  logic            accept, div_start, last_step;
  logic [W:0]      sum;
  logic [W-1:0]    sub;
  logic [2*W-1:0]  prod;
  logic [W:0]      trial;
  logic            qbit;
  logic [W-1:0]    rem_step, quo_step;

  assign accept    = In_Valid && In_Ready;
  assign div_start = accept && (ALU_FUN == 2'b11) && (B != '0);
  assign last_step = (state == S_DIV) && (cnt == CW'(1));

  // Single-cycle operations, computed from the live operands
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    sub  = A - B;
    prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};
  end

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits. The partial remainder
  // is always below the divisor, so the result fits back into W bits.
  always_comb begin
    trial    = {rem, quo[W-1]};
    qbit     = (trial >= {1'b0, dvsr});
    rem_step = qbit ? (trial[W-1:0] - dvsr) : trial[W-1:0];
    quo_step = {quo[W-2:0], qbit};
  end

  // State register and iteration counter
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (div_start)
        cnt <= CW'(W);
      else if (state == S_DIV)
        cnt <= cnt - CW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (div_start) state_nxt = S_DIV;
      S_DIV:  if (last_step) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    In_Ready = (state == S_IDLE);
    Busy     = (state == S_DIV);
  end

  // Divider working registers; they hold no meaning outside a division
  always_ff @(posedge Clk) begin
    if (div_start) begin
      quo  <= A;
      rem  <= '0;
      dvsr <= B;
    end else if (state == S_DIV) begin
      quo  <= quo_step;
      rem  <= rem_step;
    end
  end

  // Result registers; values hold until the next result
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      Arith_out   <= '0;
      Arith_hi    <= '0;
      Carry_out   <= 1'b0;
      Div_By_Zero <= 1'b0;
      Out_Valid   <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      if (accept && !div_start) begin
        Out_Valid   <= 1'b1;
        Div_By_Zero <= 1'b0;
        case (ALU_FUN)
          2'b00: begin
            Arith_out <= sum[W-1:0];
            Arith_hi  <= '0;
            Carry_out <= sum[W];
          end
          2'b01: begin
            Arith_out <= sub;
            Arith_hi  <= '0;
            Carry_out <= (A < B);
          end
          2'b10: begin
            Arith_out <= prod[W-1:0];
            Arith_hi  <= prod[2*W-1:W];
            Carry_out <= (prod[2*W-1:W] != '0);
          end
          default: begin
            // divide by zero: quotient saturates, dividend passes through
            Arith_out   <= '1;
            Arith_hi    <= A;
            Carry_out   <= 1'b0;
            Div_By_Zero <= 1'b1;
          end
        endcase
      end else if (last_step) begin
        Out_Valid   <= 1'b1;
        Arith_out   <= quo_step;
        Arith_hi    <= rem_step;
        Carry_out   <= 1'b0;
        Div_By_Zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_mc.sv
// tb_arith_unit_mc -- self-checking bench for arith_unit_mc (W = 16).
// Directed cases plus randomized operations against a plain-arithmetic model.
module tb_arith_unit_mc;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         RST;
  logic [W-1:0] A, B;
  logic [1:0]   ALU_FUN;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] Arith_out, Arith_hi;
  logic         Carry_out, Div_By_Zero, Out_Valid, Busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] last_lo, last_hi;
  logic         last_c, last_z;

  always #5 Clk = ~Clk;

  arith_unit_mc #(.DATA_WIDTH(W)) dut (
    .Clk(Clk), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Arith_out(Arith_out),
    .Arith_hi(Arith_hi), .Carry_out(Carry_out), .Div_By_Zero(Div_By_Zero),
    .Out_Valid(Out_Valid), .Busy(Busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic
  task automatic model(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic c, output logic z);
    longint m, av, bv, r;
    m  = longint'(1) << W;
    av = longint'(a);
    bv = longint'(b);
    z  = 1'b0;
    c  = 1'b0;
    hi = '0;
    case (f)
      2'd0: begin
        r  = av + bv;
        lo = W'(r % m);
        c  = (r >= m);
      end
      2'd1: begin
        lo = W'((av - bv + m) % m);
        c  = (av < bv);
      end
      2'd2: begin
        r  = av * bv;
        lo = W'(r % m);
        hi = W'(r / m);
        c  = (hi != 0);
      end
      default: begin
        if (bv == 0) begin
          lo = W'(m - 1);
          hi = a;
          z  = 1'b1;
        end else begin
          lo = W'(av / bv);
          hi = W'(av % bv);
        end
      end
    endcase
  endtask

  // Issue one request at a falling edge and check its result. With keep set,
  // In_Valid stays high and the operands churn while a divide iterates.
  task automatic run_op(input logic [1:0] fun, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit keep);
    int busy_n;
    int guard;
    model(fun, a, b, last_lo, last_hi, last_c, last_z);
    ALU_FUN  = fun;
    A        = a;
    B        = b;
    In_Valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    if (fun == 2'd3 && b != '0) begin
      if (!keep) In_Valid = 1'b0;
      busy_n = 0;
      guard  = 0;
      while (!Out_Valid && guard < 64) begin
        if (Busy && !In_Ready) busy_n++;
        if (keep) begin
          ALU_FUN = 2'($urandom_range(3, 0));
          A       = W'($urandom);
          B       = W'($urandom);
        end
        guard++;
        @(negedge Clk);
      end
      check("div_busy_cycles", 64'(busy_n), 64'd16);
    end
    check("out_valid", 64'(Out_Valid), 64'd1);
    check("arith_out", 64'(Arith_out), 64'(last_lo));
    check("arith_hi", 64'(Arith_hi), 64'(last_hi));
    check("carry_out", 64'(Carry_out), 64'(last_c));
    check("div_by_zero", 64'(Div_By_Zero), 64'(last_z));
    check("busy_after", 64'(Busy), 64'd0);
    check("in_ready_after", 64'(In_Ready), 64'd1);
    In_Valid = 1'b0;
  endtask

  // With no request, outputs hold the last result and Out_Valid stays low
  task automatic hold_check(input int n);
    for (int i = 0; i < n; i++) begin
      ALU_FUN = 2'($urandom_range(3, 0));
      A       = W'($urandom);
      B       = W'($urandom);
      @(negedge Clk);
      check("hold_out_valid", 64'(Out_Valid), 64'd0);
      check("hold_arith_out", 64'(Arith_out), 64'(last_lo));
      check("hold_arith_hi", 64'(Arith_hi), 64'(last_hi));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ov_n;
    logic [1:0]   f;
    logic [W-1:0] ra, rb;
    bit           kp;

    RST = 1'b0; In_Valid = 1'b0; A = '0; B = '0; ALU_FUN = 2'd0;
    #1;
    check("rst_in_ready", 64'(In_Ready), 64'd1);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_out_valid", 64'(Out_Valid), 64'd0);
    check("rst_arith_out", 64'(Arith_out), 64'd0);
    check("rst_arith_hi", 64'(Arith_hi), 64'd0);
    check("rst_carry", 64'(Carry_out), 64'd0);
    check("rst_dbz", 64'(Div_By_Zero), 64'd0);
    @(negedge Clk);
    RST = 1'b1;
    @(negedge Clk);

    // Directed cases
    run_op(2'd0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(2'd1, 16'd3, 16'd5, 1'b0);
    run_op(2'd1, 16'd5, 16'd3, 1'b0);
    run_op(2'd2, 16'h1234, 16'h0100, 1'b0);
    hold_check(2);
    run_op(2'd3, 16'd100, 16'd7, 1'b1);
    hold_check(3);
    run_op(2'd3, 16'h00AB, 16'h0000, 1'b0);
    run_op(2'd3, 16'hFFFF, 16'h0001, 1'b0);
    run_op(2'd3, 16'h0005, 16'hFFFF, 1'b0);

    // Reset in the middle of a division
    ALU_FUN = 2'd3; A = 16'd1000; B = 16'd3; In_Valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
    repeat (4) @(negedge Clk);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(Out_Valid), 64'd0);
    check("mid_rst_arith_out", 64'(Arith_out), 64'd0);
    check("mid_rst_arith_hi", 64'(Arith_hi), 64'd0);
    check("mid_rst_dbz", 64'(Div_By_Zero), 64'd0);
    check("mid_rst_in_ready", 64'(In_Ready), 64'd1);
    check("mid_rst_busy", 64'(Busy), 64'd0);
    repeat (2) @(negedge Clk);
    RST = 1'b1;
    run_op(2'd0, 16'd2, 16'd2, 1'b0);
    ov_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Out_Valid) ov_n++;
    end
    check("no_stale_div_result", 64'(ov_n), 64'd0);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      f  = 2'($urandom_range(3, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(3, 0))
        0: rb = '0;
        1: rb = W'($urandom_range(15, 1));
        2: ra = W'($urandom_range(255, 0));
        default: ;
      endcase
      kp = 1'($urandom_range(1, 0));
      run_op(f, ra, rb, kp);
      if ($urandom_range(3, 0) == 0) hold_check(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
